// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl: row/bit-plane scan controller for chained RGB LED panels with BCM and global dimming
// Ports: clk_i, rst_i (sync, active-low), en_i run enable, brightness_i global dimming value,
//        pix_rd_o/pix_addr_o/pix_data_i frame-buffer read port (1-cycle latency),
//        led_r_o/led_g_o/led_b_o per-panel serial data, shift_clk_o, latch_o, oe_n_o, row_sel_o panel pins,
//        frame_end_o end-of-frame pulse, busy_o high whenever not idle.
module led_matrix_scan_ctrl #(
    parameter int N_PANEL   = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int PWM_DEPTH = 8,
    parameter int CLK_DIV   = 2,
    parameter int BLANK_CYC = 4,
    parameter int DISP_UNIT = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic [PWM_DEPTH-1:0]                 brightness_i,
    output logic                                 pix_rd_o,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] pix_addr_o,
    input  logic [N_PANEL*3*PWM_DEPTH-1:0]       pix_data_i,
    output logic [N_PANEL-1:0]                   led_r_o,
    output logic [N_PANEL-1:0]                   led_g_o,
    output logic [N_PANEL-1:0]                   led_b_o,
    output logic                                 shift_clk_o,
    output logic                                 latch_o,
    output logic                                 oe_n_o,
    output logic [ROWS-1:0]                      row_sel_o,
    output logic                                 frame_end_o,
    output logic                                 busy_o
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = (PWM_DEPTH > 1) ? $clog2(PWM_DEPTH) : 1;
    localparam int WW = $clog2(DISP_UNIT + 1) + PWM_DEPTH;
    localparam int TW = WW + $clog2(2 * CLK_DIV + BLANK_CYC + 1);
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, BLANK, LATCH, DISPLAY} state_t;
    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic [PW-1:0]          plane_q, plane_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic [PWM_DEPTH-1:0]   bright_q, bright_d;
    logic [ROWS-1:0]        row_sel_q, row_sel_d;
    logic [N_PANEL-1:0]     led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;
    logic [N_PANEL-1:0]     pix_r, pix_g, pix_b;
    logic [WW-1:0]          win, on_len;
    logic [WW+PWM_DEPTH-1:0] prod;
    logic                   first_shift, shift_last, blank_last, disp_last, go_idle;
    assign win         = WW'(DISP_UNIT) << plane_q;
    assign prod        = (WW+PWM_DEPTH)'(win) * (WW+PWM_DEPTH)'(bright_q);
    assign on_len      = WW'(prod >> PWM_DEPTH);
    assign first_shift = state_q == SHIFT && cnt_q == '0;
    assign shift_last  = cnt_q == TW'(2 * CLK_DIV - 1);
    assign blank_last  = state_q == BLANK && cnt_q == TW'(BLANK_CYC - 1);
    assign disp_last   = cnt_q == TW'(win) - TW'(1);
    // Frame-buffer data is only valid in the first SHIFT cycle, so it is fed straight
    // through then and held in the led flops for the rest of the shift.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        for (int p = 0; p < N_PANEL; p++) begin
            pix_r[p] = pix_data_i[(p * 3 + 0) * PWM_DEPTH + int'(plane_q)];
            pix_g[p] = pix_data_i[(p * 3 + 1) * PWM_DEPTH + int'(plane_q)];
            pix_b[p] = pix_data_i[(p * 3 + 2) * PWM_DEPTH + int'(plane_q)];
        end
    end
    assign pix_rd_o    = state_q == FETCH;
    assign pix_addr_o  = {row_q, col_q};
    assign led_r_o     = first_shift ? pix_r : led_r_q;
    assign led_g_o     = first_shift ? pix_g : led_g_q;
    assign led_b_o     = first_shift ? pix_b : led_b_q;
    assign shift_clk_o = state_q == SHIFT && cnt_q >= TW'(CLK_DIV);
    assign latch_o     = state_q == LATCH;
    assign oe_n_o      = !(state_q == DISPLAY && cnt_q < TW'(on_len));
    assign row_sel_o   = blank_last ? ROWS'(1) << row_q : row_sel_q;
    assign frame_end_o = state_q == DISPLAY && disp_last && plane_q == '0 && row_q == RW'(ROWS - 1);
    assign busy_o      = state_q != IDLE;
    assign go_idle     = frame_end_o && !en_i;
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        plane_d   = plane_q;
        cnt_d     = cnt_q + TW'(1);
        bright_d  = bright_q;
        row_sel_d = go_idle ? '0 : row_sel_o;
        led_r_d   = go_idle ? '0 : led_r_o;
        led_g_d   = go_idle ? '0 : led_g_o;
        led_b_d   = go_idle ? '0 : led_b_o;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    row_d   = '0;
                    plane_d = PW'(PWM_DEPTH - 1);
                    col_d   = CW'(COLS - 1);
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (shift_last) begin
                cnt_d   = '0;
                col_d   = col_q - CW'(1);
                state_d = col_q == '0 ? BLANK : FETCH;
            end
            BLANK: if (cnt_q == TW'(BLANK_CYC - 1)) begin
                cnt_d   = '0;
                state_d = LATCH;
            end
            LATCH: begin
                cnt_d    = '0;
                bright_d = brightness_i;
                state_d  = DISPLAY;
            end
            DISPLAY: if (disp_last) begin
                cnt_d   = '0;
                col_d   = CW'(COLS - 1);
                plane_d = plane_q == '0 ? PW'(PWM_DEPTH - 1) : plane_q - PW'(1);
                // ROWS is a power of 2, so the row counter wraps to 0 after the last row
                row_d   = plane_q == '0 ? row_q + RW'(1) : row_q;
                state_d = go_idle ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            plane_q   <= '0;
            cnt_q     <= '0;
            bright_q  <= '0;
            row_sel_q <= '0;
            led_r_q   <= '0;
            led_g_q   <= '0;
            led_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            plane_q   <= plane_d;
            cnt_q     <= cnt_d;
            bright_q  <= bright_d;
            row_sel_q <= row_sel_d;
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            led_b_q   <= led_b_d;
        end
    end
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// tb_led_matrix_scan_ctrl: directed self-checking bench for led_matrix_scan_ctrl
module tb_led_matrix_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [3:0]  brightness_i = 4'hF;
    logic        pix_rd_o;
    logic [3:0]  pix_addr_o;
    logic [23:0] pix_data_i = '0;
    logic [1:0]  led_r_o, led_g_o, led_b_o;
    logic        shift_clk_o, latch_o, oe_n_o, frame_end_o, busy_o;
    logic [3:0]  row_sel_o;
    int          n_checks = 0;
    int          n_errs = 0;
    always #5 clk = ~clk;
    led_matrix_scan_ctrl #(
        .N_PANEL(2), .ROWS(4), .COLS(4), .PWM_DEPTH(4), .CLK_DIV(1), .BLANK_CYC(2), .DISP_UNIT(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .brightness_i(brightness_i),
        .pix_rd_o(pix_rd_o), .pix_addr_o(pix_addr_o), .pix_data_i(pix_data_i),
        .led_r_o(led_r_o), .led_g_o(led_g_o), .led_b_o(led_b_o),
        .shift_clk_o(shift_clk_o), .latch_o(latch_o), .oe_n_o(oe_n_o),
        .row_sel_o(row_sel_o), .frame_end_o(frame_end_o), .busy_o(busy_o)
    );
    // frame buffer: only {row 1, col 2} holds data, panel 1 red = 4'b1010
    always @(posedge clk) if (pix_rd_o) pix_data_i <= (pix_addr_o == 4'd6) ? 24'h00A000 : 24'h0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    int          lc, hit_cnt, lit, viol, since, fcnt = 0;
    int          lit_p[4];
    logic [3:0]  hit_planes, hit_addr, last_addr, rs_first;
    logic        other_or;
    int          s_hit_cnt, s_lit, s_viol, s_period;
    int          s_lit_p[4];
    logic [3:0]  s_hit_planes, s_hit_addr, s_rs_first, s_rs_end;
    logic        s_other, s_busy;
    always @(negedge clk) begin
        if (!rst_i) begin
            lc = 0; hit_cnt = 0; lit = 0; viol = 0; since = 0;
            lit_p = '{default: 0}; hit_planes = '0; hit_addr = '0; other_or = 1'b0; rs_first = '0;
        end else begin
            since++;
            if (pix_rd_o) last_addr = pix_addr_o;
            if (latch_o) begin
                lc++;
                if (lc == 1) rs_first = row_sel_o;
            end
            if (shift_clk_o && led_r_o[1]) begin
                hit_cnt++;
                hit_planes |= 4'(1 << (3 - lc % 4));
                hit_addr = last_addr;
            end
            other_or |= led_r_o[0] | (|led_g_o) | (|led_b_o);
            if (!oe_n_o) begin
                lit++;
                if (lc >= 1 && lc <= 4) lit_p[4 - lc]++;
                if (shift_clk_o || latch_o || pix_rd_o) viol++;
            end
            if (frame_end_o) begin
                s_hit_cnt = hit_cnt; s_hit_planes = hit_planes; s_hit_addr = hit_addr; s_other = other_or;
                s_lit = lit; s_lit_p = lit_p; s_viol = viol; s_rs_first = rs_first; s_rs_end = row_sel_o;
                s_period = since; s_busy = busy_o;
                since = 0; lc = 0; hit_cnt = 0; lit = 0; viol = 0;
                lit_p = '{default: 0}; hit_planes = '0; hit_addr = '0; other_or = 1'b0;
                fcnt++;
            end
        end
    end
    task automatic wait_frame();
        int f0 = fcnt;
        int k = 0;
        while (fcnt == f0 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("frame_seen", fcnt != f0, 1);
    endtask
    function automatic logic [15:0] pins();
        return {busy_o, oe_n_o, shift_clk_o, latch_o, pix_rd_o, frame_end_o, led_r_o, led_g_o, led_b_o, row_sel_o};
    endfunction
    initial begin
        logic [23:0] pat;
        logic [7:0]  oe_pat;
        int          k;
        pat = '0;
        oe_pat = '0;
        repeat (3) @(negedge clk);
        check("reset_pins", pins(), 16'h4000);
        check("reset_addr", pix_addr_o, 0);
        rst_i = 1'b1;
        en_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat = {pat[21:0], pix_rd_o, shift_clk_o};
            if (i % 3 == 0) check("fetch_addr", {pix_rd_o, pix_addr_o}, 16 + 3 - i / 3);
        end
        check("shift_seq", pat, 24'h861861);
        @(negedge clk);
        check("blank0", {oe_n_o, shift_clk_o, latch_o, row_sel_o}, 7'h40);
        @(negedge clk);
        check("blank1", {oe_n_o, shift_clk_o, latch_o, row_sel_o}, 7'h41);
        @(negedge clk);
        check("latch", {oe_n_o, shift_clk_o, latch_o, row_sel_o}, 7'h51);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            oe_pat = {oe_pat[6:0], oe_n_o};
        end
        check("disp_p3_oe", oe_pat, 8'h01);
        wait_frame();
        #1 brightness_i = 4'h0;
        check("f1_hits", s_hit_cnt, 2);
        check("f1_hit_planes", s_hit_planes, 4'b1010);
        check("f1_hit_addr", s_hit_addr, 4'd6);
        check("f1_other_leds", s_other, 0);
        check("f1_lit", s_lit, 44);
        check("f1_lit_p3", s_lit_p[3], 7);
        check("f1_lit_p2", s_lit_p[2], 3);
        check("f1_overlap", s_viol, 0);
        check("f1_rowsel_end", s_rs_end, 4'b1000);
        wait_frame();
        #1 brightness_i = 4'h8;
        check("f2_lit_dark", s_lit, 0);
        check("f2_period", s_period, 300);
        check("f2_rowsel_wrap", s_rs_first, 4'b0001);
        repeat (17) @(posedge clk);
        #1 brightness_i = 4'hF;
        repeat (4) @(posedge clk);
        #1 brightness_i = 4'h8;
        wait_frame();
        check("f3_lit", s_lit, 28);
        check("f3_lit_p3", s_lit_p[3], 4);
        check("f3_lit_p0", s_lit_p[0], 0);
        check("f3_period", s_period, 300);
        repeat (100) @(posedge clk);
        #1 en_i = 1'b0;
        wait_frame();
        check("f4_period", s_period, 300);
        check("f4_busy_at_end", s_busy, 1);
        check("f4_lit", s_lit, 28);
        @(negedge clk);
        check("stop_idle", pins(), 16'h4000);
        repeat (3) @(negedge clk);
        check("stay_idle", pins(), 16'h4000);
        en_i = 1'b1;
        k = 0;
        while (lc != 9 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("row2_reached", lc, 9);
        @(negedge clk);
        check("row2_disp", {oe_n_o, row_sel_o}, 5'b00100);
        rst_i = 1'b0;
        @(negedge clk);
        check("midreset_pins", pins(), 16'h4000);
        rst_i = 1'b1;
        @(negedge clk);
        check("restart_fetch", {pix_rd_o, pix_addr_o}, 5'h13);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
